gqed_fc_monitor: RTL and testbench
==================================

Name: gqed_fc_monitor

Overview:
- Parametrised successor to the single-pipe G-QED harness. Synthesizable and simulatable run-time functional-consistency checker.
- Watches two independent copies of a DUT, A and B. The copies may be fed different prefix streams.
- For each copy it locates a programmable target transaction index and samples the copy's architectural state just before that transaction is accepted.
- It then captures NUM_OUT consecutive responses starting at that index. If the two architectural states match, it compares the captured responses and flags any difference.
- Sits beside the DUT copies in the G-QED bench and in on-chip self-test wrappers.

Parameters:
- DATA_W, 2, response data width.
- STATE_W, 2, architectural state width.
- IDX_W, 5, transaction index width.
- NUM_OUT, 2, responses captured per copy. Range 1..8.
- TIMEOUT_CYC, 16, maximum cycles from target-input acceptance to capture completion.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  pulse; arms a check when in IDLE or DONE.
- idx_a  in  IDX_W  target transaction index, copy A.
- idx_b  in  IDX_W  target transaction index, copy B.
- a_in_fire  in  1  copy A accepted an input this cycle.
- a_out_vld  in  1  copy A response valid.
- a_out  in  DATA_W  copy A response.
- a_arch_st  in  STATE_W  copy A architectural state.
- b_in_fire, b_out_vld, b_out, b_arch_st  as above, for copy B.
- busy  out  1  check in progress.
- done  out  1  verdict valid.
- fc_pass  out  1  states equal and responses equal.
- fc_fail  out  1  states equal and responses differ.
- arch_mismatch  out  1  states differ; check inconclusive.
- timeout  out  1  a copy did not complete capture within TIMEOUT_CYC.

Behaviour:
- Reset: asynchronous. FSM=IDLE. All counters, buffers and flags cleared. Every output is 0.
- FSM states: IDLE, RUN, CMP, DONE.
  - IDLE/DONE -> RUN on start. Latches idx_a/idx_b, clears all counters, buffers and verdict flags. busy=1 from the next cycle.
  - start while in RUN or CMP is ignored.
- Per-copy logic in RUN (A and B independent and identical):
  - in_cnt increments on in_fire. It saturates at 2^IDX_W-1.
  - On in_fire with in_cnt==idx: sample arch_st into arch_reg, set arch_done, start the timer at 0.
  - out_cnt increments on out_vld. Responses are in order, one per input.
  - On out_vld with idx <= out_cnt < idx+NUM_OUT: write out into buf[out_cnt-idx]. When slot NUM_OUT-1 is written, set cap_done.
  - Index arithmetic is IDX_W+1 bits wide, so idx+NUM_OUT does not wrap.
  - Timer increments each cycle while arch_done && !cap_done. When it reaches TIMEOUT_CYC, set timeout.
  - in_fire and out_vld in the same cycle are both processed. The target output may arrive in the same cycle the target input is accepted; it is captured.
- RUN -> CMP when both cap_done are set, or when timeout is set. That cycle, busy stays 1.
- CMP (1 cycle) -> DONE. Exactly one verdict is set:
  - timeout set: timeout=1.
  - else arch_reg_a != arch_reg_b: arch_mismatch=1.
  - else all NUM_OUT buffer slots equal: fc_pass=1.
  - else: fc_fail=1.
- DONE: busy=0, done=1. Verdict held until the next start or reset. Latency from the final capture to done is 2 cycles.
- Reset asserted mid-operation returns the block immediately to IDLE with all outputs 0.
- idx==0: arch_st is sampled on the very first in_fire.

Test Plan:
- DATA_W=2, NUM_OUT=2, idx_a=3, idx_b=0. Both copies have arch_st=2 at their target. A responses at indices 3,4 = {1,3}; B responses at 0,1 = {1,3} -> done=1, fc_pass=1, 2 cycles after the final capture.
- Same setup, but B's second response = 2 -> fc_fail=1, fc_pass=0.
- Same setup, but arch_st A=2, B=1 at their targets, responses equal -> arch_mismatch=1, fc_fail=0.
- TIMEOUT_CYC=16. Copy B never asserts out_vld after its target input -> timeout=1 exactly 16 cycles after B's target in_fire; done=1 2 cycles later.
- Target input and target output in the same cycle on A; in_fire and out_vld concurrent on every cycle -> correct capture, fc_pass=1.
- rst asserted at cycle 5 of RUN -> all outputs 0 asynchronously. A fresh start with idx_a=idx_b=1 then passes normally; start pulsed during RUN is ignored.

Source files
------------

// File: rtl/gqed_fc_if.sv
// Observation bundle between two DUT copies, the G-QED harness control and the
// functional-consistency monitor. master drives stimulus/observations, slave is the monitor.
interface gqed_fc_if #(
    parameter int DATA_W  = 2,
    parameter int STATE_W = 2,
    parameter int IDX_W   = 5
);
    logic               start;
    logic [IDX_W-1:0]   idx_a;
    logic [IDX_W-1:0]   idx_b;
    logic               a_in_fire;
    logic               a_out_vld;
    logic [DATA_W-1:0]  a_out;
    logic [STATE_W-1:0] a_arch_st;
    logic               b_in_fire;
    logic               b_out_vld;
    logic [DATA_W-1:0]  b_out;
    logic [STATE_W-1:0] b_arch_st;
    logic               busy;
    logic               done;
    logic               fc_pass;
    logic               fc_fail;
    logic               arch_mismatch;
    logic               timeout;

    modport master (
        output start, idx_a, idx_b,
        output a_in_fire, a_out_vld, a_out, a_arch_st,
        output b_in_fire, b_out_vld, b_out, b_arch_st,
        input  busy, done, fc_pass, fc_fail, arch_mismatch, timeout
    );

    modport slave (
        input  start, idx_a, idx_b,
        input  a_in_fire, a_out_vld, a_out, a_arch_st,
        input  b_in_fire, b_out_vld, b_out, b_arch_st,
        output busy, done, fc_pass, fc_fail, arch_mismatch, timeout
    );
endinterface

// File: rtl/gqed_fc_monitor.sv
// Run-time functional-consistency checker: samples each copy's architectural state at a
// target transaction, captures NUM_OUT responses from there and compares the two copies.
module gqed_fc_monitor #(
    parameter int DATA_W      = 2,
    parameter int STATE_W     = 2,
    parameter int IDX_W       = 5,
    parameter int NUM_OUT     = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input logic     clk,
    input logic     rst,
    gqed_fc_if.slave bus
);
    localparam int CW = IDX_W + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    CW_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0]    TW_ONE   = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IN_MAX   = {IDX_W{1'b1}};
    localparam logic [CW-1:0]    OUT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0]    LAST_REL = CW'(NUM_OUT) - CW_ONE;
    localparam logic [TW-1:0]    TO_LAST  = TW'(TIMEOUT_CYC) - TW_ONE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_r;
    logic               busy_r, done_r, pass_r, fail_r, mism_r, timeout_r;

    logic [1:0]         in_fire_s, out_vld_s, in_win_s;
    logic [DATA_W-1:0]  out_s     [2];
    logic [STATE_W-1:0] arch_st_s [2];
    logic [IDX_W-1:0]   idx_s     [2];
    logic [CW-1:0]      rel_s     [2];
    logic               start_acc_s, bufs_eq_s;

    logic [IDX_W-1:0]   idx_r     [2];
    logic [IDX_W-1:0]   in_cnt_r  [2];
    logic [CW-1:0]      out_cnt_r [2];
    logic [STATE_W-1:0] arch_r    [2];
    logic [TW-1:0]      timer_r   [2];
    logic [DATA_W-1:0]  buf_r     [2][NUM_OUT];
    logic [1:0]         arch_done_r, cap_done_r;

    assign in_fire_s    = {bus.b_in_fire, bus.a_in_fire};
    assign out_vld_s    = {bus.b_out_vld, bus.a_out_vld};
    assign out_s[0]     = bus.a_out;
    assign out_s[1]     = bus.b_out;
    assign arch_st_s[0] = bus.a_arch_st;
    assign arch_st_s[1] = bus.b_arch_st;
    assign idx_s[0]     = bus.idx_a;
    assign idx_s[1]     = bus.idx_b;
    assign start_acc_s  = bus.start && ((state_r == IDLE) || (state_r == DONE));

    // Capture window decode and buffer comparison, widened so idx+NUM_OUT never wraps
    always_comb begin
        bufs_eq_s = 1'b1;
        for (int c = 0; c < 2; c++) begin
            rel_s[c]    = out_cnt_r[c] - {1'b0, idx_r[c]};
            in_win_s[c] = (out_cnt_r[c] >= {1'b0, idx_r[c]}) && (rel_s[c] <= LAST_REL);
        end
        for (int s = 0; s < NUM_OUT; s++) begin
            bufs_eq_s = bufs_eq_s & (buf_r[0][s] == buf_r[1][s]);
        end
    end

    // Per-copy counters, state sampling, response capture and timeout timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_r   <= 1'b0;
            arch_done_r <= 2'b00;
            cap_done_r  <= 2'b00;
            for (int c = 0; c < 2; c++) begin
                idx_r[c]     <= '0;
                in_cnt_r[c]  <= '0;
                out_cnt_r[c] <= '0;
                arch_r[c]    <= '0;
                timer_r[c]   <= '0;
                for (int s = 0; s < NUM_OUT; s++) buf_r[c][s] <= '0;
            end
        end else if (start_acc_s) begin
            timeout_r   <= 1'b0;
            arch_done_r <= 2'b00;
            cap_done_r  <= 2'b00;
            for (int c = 0; c < 2; c++) begin
                idx_r[c]     <= idx_s[c];
                in_cnt_r[c]  <= '0;
                out_cnt_r[c] <= '0;
                arch_r[c]    <= '0;
                timer_r[c]   <= '0;
                for (int s = 0; s < NUM_OUT; s++) buf_r[c][s] <= '0;
            end
        end else if (state_r == RUN) begin
            for (int c = 0; c < 2; c++) begin
                if (in_fire_s[c] && (in_cnt_r[c] != IN_MAX)) begin
                    in_cnt_r[c] <= in_cnt_r[c] + IDX_ONE;
                end
                // Saturated in_cnt would otherwise re-sample at index 2^IDX_W-1
                if (in_fire_s[c] && (in_cnt_r[c] == idx_r[c]) && !arch_done_r[c]) begin
                    arch_r[c]      <= arch_st_s[c];
                    arch_done_r[c] <= 1'b1;
                    timer_r[c]     <= '0;
                end else if (arch_done_r[c] && !cap_done_r[c] && !timeout_r) begin
                    timer_r[c] <= timer_r[c] + TW_ONE;
                    if (timer_r[c] == TO_LAST) timeout_r <= 1'b1;
                end
                if (out_vld_s[c]) begin
                    if (out_cnt_r[c] != OUT_MAX) out_cnt_r[c] <= out_cnt_r[c] + CW_ONE;
                    if (in_win_s[c]) begin
                        for (int s = 0; s < NUM_OUT; s++) begin
                            if (rel_s[c] == CW'(s)) buf_r[c][s] <= out_s[c];
                        end
                        if (rel_s[c] == LAST_REL) cap_done_r[c] <= 1'b1;
                    end
                end
            end
        end
    end

    // Control FSM with registered status and verdict outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            fail_r  <= 1'b0;
            mism_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        pass_r  <= 1'b0;
                        fail_r  <= 1'b0;
                        mism_r  <= 1'b0;
                    end
                end
                RUN: begin
                    if ((cap_done_r == 2'b11) || timeout_r) state_r <= CMP;
                end
                CMP: begin
                    state_r <= DONE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    if (!timeout_r) begin
                        if (arch_r[0] != arch_r[1]) mism_r <= 1'b1;
                        else if (bufs_eq_s)         pass_r <= 1'b1;
                        else                        fail_r <= 1'b1;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.fc_pass       = pass_r;
    assign bus.fc_fail       = fail_r;
    assign bus.arch_mismatch = mism_r;
    assign bus.timeout       = timeout_r;
endmodule

// File: tb/tb_gqed_fc_monitor.sv
// Scoreboard bench for gqed_fc_monitor: schedules are generated up front, a transaction-level
// model predicts verdict and done cycle, and a monitor process checks each done pulse.
module tb_gqed_fc_monitor;
    localparam int DW = 2, SW = 2, IW = 5, NO = 2, TO = 16, MAXL = 120;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gqed_fc_if #(.DATA_W(DW), .STATE_W(SW), .IDX_W(IW)) bus ();
    gqed_fc_monitor #(.DATA_W(DW), .STATE_W(SW), .IDX_W(IW), .NUM_OUT(NO), .TIMEOUT_CYC(TO))
        dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [3:0] verdict;   // {fc_pass, fc_fail, arch_mismatch, timeout}
        int         done_edge;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0, n_fail = 0, edge_cnt = 0, to_edge = -1;
    logic done_q = 1'b0, to_q = 1'b0;

    // Per-copy transaction contents: state before input i, response to input i
    logic [SW-1:0] arch_m [2][64];
    logic [DW-1:0] resp_m [2][64];
    // Cycle-by-cycle replay schedule
    bit            fire_k [2][MAXL];
    bit            vld_k  [2][MAXL];
    logic [SW-1:0] arch_k [2][MAXL];
    logic [DW-1:0] out_k  [2][MAXL];
    int            len_k;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every rising done and checks verdict and timing
    always @(negedge clk) begin
        if (bus.timeout && !to_q) to_edge = edge_cnt;
        if (bus.done && !done_q) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("verdict", {28'd0, bus.fc_pass, bus.fc_fail, bus.arch_mismatch, bus.timeout},
                      {28'd0, mon_e.verdict});
                check("done_edge", edge_cnt, mon_e.done_edge);
                check("busy_at_done", {31'd0, bus.busy}, 32'd0);
            end
        end
        done_q = bus.done;
        to_q   = bus.timeout;
    end

    task automatic idle();
        bus.start = 1'b0;
        bus.a_in_fire = 1'b0; bus.a_out_vld = 1'b0; bus.a_out = '0; bus.a_arch_st = '0;
        bus.b_in_fire = 1'b0; bus.b_out_vld = 1'b0; bus.b_out = '0; bus.b_arch_st = '0;
    endtask

    task automatic fill_random();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 64; i++) begin
                arch_m[c][i] = SW'($urandom);
                resp_m[c][i] = DW'($urandom);
            end
    endtask

    // Build a schedule and predict the outcome from transaction indices and cycle numbers
    task automatic gen(input int ia, input int ib, input int pf, input int pv, input bit kill_b,
                       output logic [3:0] verdict, output int rel_done);
        int idx[2], e0[2], cc[2], fin[2];
        int ic, oc, nin, t_to, m;
        bit f, v, any_to, arch_eq, resp_eq;
        idx[0] = ia; idx[1] = ib;
        for (int c = 0; c < 2; c++) begin
            ic = 0; oc = 0; e0[c] = -1; cc[c] = -1; fin[c] = -1;
            nin = idx[c] + NO + int'($urandom_range(0, 2));
            for (int k = 0; k < MAXL; k++) begin
                f = (ic < nin) && ($urandom_range(1, 100) <= pf);
                v = (oc < ic + int'(f)) && (oc < nin) && !(kill_b && c == 1 && oc >= idx[c])
                    && ($urandom_range(1, 100) <= pv);
                fire_k[c][k] = f;
                vld_k[c][k]  = v;
                arch_k[c][k] = f ? arch_m[c][ic] : SW'($urandom);
                out_k[c][k]  = v ? resp_m[c][oc] : DW'($urandom);
                if (f && ic == idx[c]) e0[c] = k;
                if (v && oc == idx[c] + NO - 1) cc[c] = k;
                ic += int'(f);
                oc += int'(v);
                if (fin[c] < 0 && ic == nin && (oc == nin || (kill_b && c == 1))) fin[c] = k + 1;
            end
            if (fin[c] < 0) fin[c] = MAXL;
        end
        len_k = (fin[0] > fin[1]) ? fin[0] : fin[1];
        any_to = 1'b0; t_to = MAXL * 4;
        for (int c = 0; c < 2; c++) begin
            if (cc[c] < 0 || cc[c] - e0[c] >= TO) begin
                any_to = 1'b1;
                if (e0[c] + TO < t_to) t_to = e0[c] + TO;
            end
        end
        arch_eq = (arch_m[0][ia] == arch_m[1][ib]);
        resp_eq = 1'b1;
        for (int j = 0; j < NO; j++)
            if (resp_m[0][ia + j] != resp_m[1][ib + j]) resp_eq = 1'b0;
        m = (cc[0] > cc[1]) ? cc[0] : cc[1];
        if (any_to) begin
            verdict = 4'b0001; rel_done = t_to + 2;
        end else begin
            rel_done = m + 2;
            if (!arch_eq)     verdict = 4'b0010;
            else if (resp_eq) verdict = 4'b1000;
            else              verdict = 4'b0100;
        end
    endtask

    task automatic run(input int ia, input int ib, input int pf, input int pv, input bit kill_b,
                       input bit mid_start, input int abort_at, output int s);
        logic [3:0] v;
        int rd;
        gen(ia, ib, pf, pv, kill_b, v, rd);
        @(posedge clk); #1;
        s = edge_cnt + 1;
        if (abort_at < 0) sb_q.push_back('{v, s + 1 + rd});
        bus.start = 1'b1; bus.idx_a = IW'(ia); bus.idx_b = IW'(ib);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < len_k; k++) begin
            if (k == abort_at) begin
                check("busy_in_run", {31'd0, bus.busy}, 32'd1);
                rst = 1'b1;
                #1;
                check("async_reset_outs", {26'd0, bus.busy, bus.done, bus.fc_pass, bus.fc_fail,
                      bus.arch_mismatch, bus.timeout}, 32'd0);
                idle();
                #2 rst = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                check("post_reset_outs", {26'd0, bus.busy, bus.done, bus.fc_pass, bus.fc_fail,
                      bus.arch_mismatch, bus.timeout}, 32'd0);
                return;
            end
            bus.a_in_fire = fire_k[0][k]; bus.a_out_vld = vld_k[0][k];
            bus.a_arch_st = arch_k[0][k]; bus.a_out     = out_k[0][k];
            bus.b_in_fire = fire_k[1][k]; bus.b_out_vld = vld_k[1][k];
            bus.b_arch_st = arch_k[1][k]; bus.b_out     = out_k[1][k];
            bus.start = mid_start && (k == 2);
            if (mid_start && k == 2) begin
                bus.idx_a = IW'(ia + 5); bus.idx_b = IW'(ib + 7);
            end
            @(posedge clk); #1;
        end
        idle();
        for (int i = 0; i < 60 && !bus.done; i++) begin
            @(posedge clk); #1;
        end
        check("done_seen", {31'd0, bus.done}, 32'd1);
    endtask

    task automatic set_directed(input logic [SW-1:0] sa, input logic [SW-1:0] sb,
                                input logic [DW-1:0] b2nd);
        fill_random();
        arch_m[0][3] = sa;    arch_m[1][0] = sb;
        resp_m[0][3] = 2'd1;  resp_m[0][4] = 2'd3;
        resp_m[1][0] = 2'd1;  resp_m[1][1] = b2nd;
    endtask

    initial begin
        int s, ia, ib;
        rst = 1'b1;
        idle();
        bus.idx_a = '0; bus.idx_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {26'd0, bus.busy, bus.done, bus.fc_pass, bus.fc_fail,
              bus.arch_mismatch, bus.timeout}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_outs", {26'd0, bus.busy, bus.done, bus.fc_pass, bus.fc_fail,
              bus.arch_mismatch, bus.timeout}, 32'd0);

        // Directed: pass, fail, arch mismatch, timeout (all with concurrent fire/vld)
        set_directed(2'd2, 2'd2, 2'd3); run(3, 0, 100, 100, 1'b0, 1'b0, -1, s);
        set_directed(2'd2, 2'd2, 2'd2); run(3, 0, 100, 100, 1'b0, 1'b0, -1, s);
        set_directed(2'd2, 2'd1, 2'd3); run(3, 0, 100, 100, 1'b0, 1'b0, -1, s);
        set_directed(2'd2, 2'd2, 2'd3); to_edge = -1;
        run(3, 0, 100, 100, 1'b1, 1'b0, -1, s);
        check("timeout_edge", to_edge, s + 1 + TO);

        // Reset mid-RUN, then a fresh check with a start pulse that must be ignored
        fill_random();
        run(8, 8, 60, 60, 1'b0, 1'b0, 5, s);
        fill_random();
        arch_m[1][1] = arch_m[0][1];
        resp_m[1][1] = resp_m[0][1]; resp_m[1][2] = resp_m[0][2];
        run(1, 1, 100, 100, 1'b0, 1'b1, -1, s);

        // Randomized checks
        for (int t = 0; t < 16; t++) begin
            fill_random();
            ia = int'($urandom_range(0, 10));
            ib = int'($urandom_range(0, 10));
            if ($urandom_range(0, 1) == 1) arch_m[1][ib] = arch_m[0][ia];
            if ($urandom_range(0, 2) != 0)
                for (int j = 0; j < NO; j++) resp_m[1][ib + j] = resp_m[0][ia + j];
            run(ia, ib, int'($urandom_range(40, 100)), int'($urandom_range(40, 100)),
                1'b0, 1'b0, -1, s);
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
